// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared constants and types for the PS/2 mouse receiver.
//  Revision    : 1.0  initial release
// ============================================================================
package ps2_pkg;

    localparam int FRAME_BITS = 11;

    // byte0 (status byte) bit positions
    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_M = 2;
    localparam int SYNC  = 3;
    localparam int XSIGN = 4;
    localparam int YSIGN = 5;
    localparam int XOVF  = 6;
    localparam int YOVF  = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } bit_state_t;

endpackage
`default_nettype wire

// File: rtl/ps2_byte_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_byte_rx
//  Description : PS/2 line synchroniser and 11-bit frame deserialiser with
//                parity/stop checking and mid-frame timeout.
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_byte_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 5000,
    parameter int CNT_W       = 13
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_err
);

    // Abort is registered one cycle early so the error pulse lands exactly
    // TIMEOUT_CYC cycles after the last falling edge.
    localparam logic [CNT_W-1:0] c_tmo_last = CNT_W'(TIMEOUT_CYC - 2);
    localparam logic [3:0]       c_last_bit = 4'(FRAME_BITS - 2);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   r_clk_prev;
    bit_state_t             r_state;
    logic [3:0]             r_cnt;
    logic [8:0]             r_shift;
    logic [CNT_W-1:0]       r_tcnt;

    logic       w_fall;
    logic       w_dat;
    logic [9:0] w_next;
    logic       w_good;

    assign w_fall = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
    assign w_dat  = r_dat_sync[SYNC_STAGES-1];
    // w_next = {stop, parity, data[7:0]} when the final bit is being sampled
    assign w_next = {w_dat, r_shift};
    assign w_good = (^w_next[8:0]) & w_next[9];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_sync   <= '1;
            r_dat_sync   <= '1;
            r_clk_prev   <= 1'b1;
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_tcnt       <= '0;
            o_byte       <= '0;
            o_byte_valid <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            r_clk_sync   <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
            r_dat_sync   <= {r_dat_sync[SYNC_STAGES-2:0], i_ps2_dat};
            r_clk_prev   <= r_clk_sync[SYNC_STAGES-1];
            o_byte_valid <= 1'b0;
            o_err        <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_tcnt <= '0;
                    if (w_fall && !w_dat) begin
                        r_state <= SHIFT;
                        r_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    if (w_fall) begin
                        r_tcnt  <= '0;
                        r_shift <= w_next[9:1];
                        r_cnt   <= r_cnt + 4'd1;
                        if (r_cnt == c_last_bit) begin
                            r_state      <= CHECK;
                            o_byte       <= w_next[7:0];
                            o_byte_valid <= w_good;
                            o_err        <= ~w_good;
                        end
                    end else if (r_tcnt == c_tmo_last) begin
                        r_state <= IDLE;
                        r_tcnt  <= '0;
                        o_err   <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                CHECK: begin
                    r_state <= IDLE;
                    r_tcnt  <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_mouse_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_mouse_rx
//  Description : Receive-only PS/2 mouse front end; assembles 3-byte
//                stream-mode packets into buttons and signed 9-bit deltas.
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_mouse_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 5000,
    parameter int CNT_W       = 13
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       pkt_valid,
    output logic [2:0] btn,
    output logic [8:0] dx,
    output logic [8:0] dy,
    output logic       x_ovf,
    output logic       y_ovf,
    output logic       frame_err
);

    logic [7:0] w_byte;
    logic       w_byte_valid;
    logic       w_err;
    logic       w_unused_sync;

    logic [1:0] r_idx;
    logic [7:0] r_b0;
    logic [7:0] r_b1;

    ps2_byte_rx #(
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) u_byte_rx (
        .clk          (clk_clk),
        .rst          (reset_reset),
        .i_ps2_clk    (ps2_clk),
        .i_ps2_dat    (ps2_dat),
        .o_byte       (w_byte),
        .o_byte_valid (w_byte_valid),
        .o_err        (w_err)
    );

    assign frame_err     = w_err;
    assign w_unused_sync = r_b0[SYNC];

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_idx     <= 2'd0;
            r_b0      <= '0;
            r_b1      <= '0;
            pkt_valid <= 1'b0;
            btn       <= '0;
            dx        <= '0;
            dy        <= '0;
            x_ovf     <= 1'b0;
            y_ovf     <= 1'b0;
        end else begin
            pkt_valid <= 1'b0;
            if (w_err) begin
                r_idx <= 2'd0;
            end else if (w_byte_valid) begin
                case (r_idx)
                    2'd0: begin
                        // Bytes without the sync bit are dropped to regain alignment
                        if (w_byte[SYNC]) begin
                            r_b0  <= w_byte;
                            r_idx <= 2'd1;
                        end
                    end
                    2'd1: begin
                        r_b1  <= w_byte;
                        r_idx <= 2'd2;
                    end
                    default: begin
                        r_idx     <= 2'd0;
                        pkt_valid <= 1'b1;
                        btn       <= r_b0[BTN_M:BTN_L];
                        dx        <= {r_b0[XSIGN], r_b1};
                        dy        <= {r_b0[YSIGN], w_byte};
                        x_ovf     <= r_b0[XOVF];
                        y_ovf     <= r_b0[YOVF];
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
